// File: rtl/mixer_pkg.sv
// Shared Q-format widths, product shift and sequencer state type
// for the mixing accumulator and its multiplier.
package mixer_pkg;

   localparam int SAMPLE_W   = 24;
   localparam int GAIN_W     = 18;
   localparam int ACC_W      = 36;
   // Q1.23 * Q6.12 = Q7.35; dropping 6 LSBs gives Q7.29
   localparam int PROD_SHIFT = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_e;

endpackage

// File: rtl/mul_trunc.sv
// Registered full-width signed sample*gain product, then arithmetic
// shift with truncation to accumulator width.
// Ports: clk, reset_n, en_i (capture), sample_i, gain_i -> res_o.
module mul_trunc
   import mixer_pkg::*;
#(
   parameter int SW = SAMPLE_W,
   parameter int GW = GAIN_W,
   parameter int AW = ACC_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en_i,
   input  logic [SW-1:0] sample_i,
   input  logic [GW-1:0] gain_i,
   output logic [AW-1:0] res_o
);

   localparam int PW = SW + GW;

   logic signed [PW-1:0] s_ext;
   logic signed [PW-1:0] g_ext;
   logic signed [PW-1:0] prod_d;
   logic signed [PW-1:0] prod_q;

   // Sign-extend first so the PW-bit product is exact
   assign s_ext  = PW'($signed(sample_i));
   assign g_ext  = PW'($signed(gain_i));
   assign prod_d = s_ext * g_ext;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prod_q <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   assign res_o = AW'(prod_q >>> PROD_SHIFT);

endmodule

// File: rtl/mix_accumulator.sv
// Frame sequencer and per-bus accumulator for a channel mixer.
// Ports: clk, reset_n, start/ready handshake, sample/gain memory
// addresses and read data, acc_out/acc_valid/acc_bus result strobe.
module mix_accumulator
   import mixer_pkg::*;
#(
   parameter int NUM_CHANNELS = 8,
   parameter int NUM_BUSES    = 2,
   parameter int SAMPLE_WIDTH = SAMPLE_W,
   parameter int GAIN_WIDTH   = GAIN_W,
   parameter int ACC_WIDTH    = ACC_W,
   localparam int CW  = $clog2(NUM_CHANNELS),
   localparam int TOT = NUM_BUSES * NUM_CHANNELS,
   localparam int GA  = $clog2(TOT),
   localparam int BW  = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    ready,
   output logic [CW-1:0]           sample_addr,
   output logic [GA-1:0]           gain_addr,
   input  logic [SAMPLE_WIDTH-1:0] sample_data,
   input  logic [GAIN_WIDTH-1:0]   gain_data,
   output logic [ACC_WIDTH-1:0]    acc_out,
   output logic                    acc_valid,
   output logic [BW-1:0]           acc_bus
);

   state_e state_q;
   logic   ready_q;
   logic [1:0] drain_q;

   logic [CW-1:0] sample_addr_q;
   logic [GA-1:0] gain_addr_q;
   logic [BW-1:0] bus_q;

   // Stage 2: read data returning; stage 3: product registered
   logic          v2_q, f2_q, l2_q;
   logic [BW-1:0] b2_q;
   logic          v3_q, f3_q, l3_q;
   logic [BW-1:0] b3_q;

   logic [ACC_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] acc_d;
   logic [ACC_WIDTH-1:0] acc_out_q;
   logic                 acc_valid_q;
   logic [BW-1:0]        acc_bus_q;

   mul_trunc #(
      .SW (SAMPLE_WIDTH),
      .GW (GAIN_WIDTH),
      .AW (ACC_WIDTH)
   ) u_mul (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_i     (v2_q),
      .sample_i (sample_data),
      .gain_i   (gain_data),
      .res_o    (prod)
   );

   // First channel of a bus restarts the sum; wraps mod 2^ACC_WIDTH
   assign acc_d = f3_q ? prod : acc_q + prod;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b1;
         drain_q       <= '0;
         sample_addr_q <= '0;
         gain_addr_q   <= '0;
         bus_q         <= '0;
         v2_q          <= 1'b0;
         f2_q          <= 1'b0;
         l2_q          <= 1'b0;
         b2_q          <= '0;
         v3_q          <= 1'b0;
         f3_q          <= 1'b0;
         l3_q          <= 1'b0;
         b3_q          <= '0;
         acc_q         <= '0;
         acc_out_q     <= '0;
         acc_valid_q   <= 1'b0;
         acc_bus_q     <= '0;
      end else begin
         v2_q <= (state_q == ST_RUN);
         f2_q <= (sample_addr_q == '0);
         l2_q <= (sample_addr_q == CW'(NUM_CHANNELS - 1));
         b2_q <= bus_q;
         v3_q <= v2_q;
         f3_q <= f2_q;
         l3_q <= l2_q;
         b3_q <= b2_q;

         acc_valid_q <= 1'b0;
         if (v3_q) begin
            acc_q <= acc_d;
            // Output copy lets the next bus reuse acc_q immediately
            if (l3_q) begin
               acc_out_q   <= acc_d;
               acc_bus_q   <= b3_q;
               acc_valid_q <= 1'b1;
            end
         end

         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q       <= ST_RUN;
                  ready_q       <= 1'b0;
                  sample_addr_q <= '0;
                  gain_addr_q   <= '0;
                  bus_q         <= '0;
               end
            end
            ST_RUN: begin
               if (gain_addr_q == GA'(TOT - 1)) begin
                  state_q <= ST_DRAIN;
                  drain_q <= '0;
               end else begin
                  sample_addr_q <= sample_addr_q + CW'(1);
                  gain_addr_q   <= gain_addr_q + GA'(1);
                  if (sample_addr_q == CW'(NUM_CHANNELS - 1)) begin
                     bus_q <= bus_q + BW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // Three cycles cover the read, multiply and add stages
               if (drain_q == 2'd2) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready       = ready_q;
   assign sample_addr = sample_addr_q;
   assign gain_addr   = gain_addr_q;
   assign acc_out     = acc_out_q;
   assign acc_valid   = acc_valid_q;
   assign acc_bus     = acc_bus_q;

endmodule
